mult_div_ctrl: RTL

//  Sequencer plus iterative engine for the MULT/DIV instructions of the multicycle CPU.
//  The main control unit pulses start with operands A/B and waits on done/div0.

---
 rtl/mult_div_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mult_div_ctrl.sv
// Iterative signed multiply/divide engine with its sequencer for the MULT/DIV instructions.
// The engine works on operand magnitudes and fixes up the signs in a single SIGN cycle.
module mult_div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             abort,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic             hi_we,
  output logic             lo_we,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {StIdle, StCalc, StSign, StDone, StDivz} state_e;

  state_e           state;
  logic [CW-1:0]    cnt;
  logic             op_q;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] b_mag_q;
  // upper: MULT high accumulator / DIV remainder; lower: MULT low product / DIV quotient
  logic [WIDTH-1:0] upper;
  logic [WIDTH-1:0] lower;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   calc_upper;
  logic [WIDTH-1:0]   calc_lower;
  logic [2*WIDTH-1:0] prod_abs;
  logic [2*WIDTH-1:0] prod_sgn;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
  assign a_mag = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
  assign b_mag = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;

  always_comb begin
    mul_sum    = {1'b0, upper} + (lower[0] ? {1'b0, b_mag_q} : {(WIDTH + 1){1'b0}});
    div_sh     = {upper, lower[WIDTH-1]};
    div_diff   = div_sh - {1'b0, b_mag_q};
    div_ge     = (div_sh >= {1'b0, b_mag_q});
    calc_upper = upper;
    calc_lower = lower;
    if (op_q) begin
      calc_upper = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      calc_lower = {lower[WIDTH-2:0], div_ge};
    end else begin
      // The add's carry shifts back into the top of the accumulator.
      calc_upper = mul_sum[WIDTH:1];
      calc_lower = {mul_sum[0], lower[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_abs = {upper, lower};
    prod_sgn = (sign_a ^ sign_b) ? (~prod_abs + 1'b1) : prod_abs;
    if (op_q) begin
      res_lo = (sign_a ^ sign_b) ? (~lower + 1'b1) : lower;
      res_hi = sign_a ? (~upper + 1'b1) : upper;
    end else begin
      res_lo = prod_sgn[WIDTH-1:0];
      res_hi = prod_sgn[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= StIdle;
      cnt     <= '0;
      op_q    <= 1'b0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      b_mag_q <= '0;
      upper   <= '0;
      lower   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      div0    <= 1'b0;
      hi_out  <= '0;
      lo_out  <= '0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      if (abort) begin
        // Cancel from any state; a concurrent start in IDLE is dropped as well.
        state <= StIdle;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            if (start) begin
              op_q    <= op;
              sign_a  <= a_in[WIDTH-1];
              sign_b  <= b_in[WIDTH-1];
              b_mag_q <= b_mag;
              upper   <= '0;
              lower   <= a_mag;
              busy    <= 1'b1;
              if (op && (b_in == '0)) begin
                state <= StDivz;
                div0  <= 1'b1;
              end else begin
                state <= StCalc;
                cnt   <= CW'(WIDTH - 1);
              end
            end
          end
          StCalc: begin
            upper <= calc_upper;
            lower <= calc_lower;
            if (cnt == '0) begin
              state <= StSign;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          StSign: begin
            hi_out <= res_hi;
            lo_out <= res_lo;
            done   <= 1'b1;
            state  <= StDone;
          end
          StDone, StDivz: begin
            busy  <= 1'b0;
            state <= StIdle;
          end
          default: begin
            busy  <= 1'b0;
            state <= StIdle;
          end
        endcase
      end
    end
  end

  assign hi_we = done;
  assign lo_we = done;

endmodule
